jtag_tap_ctrl: RTL and testbench
================================

Name: jtag_tap_ctrl

Overview:
- Parametrised JTAG TAP controller: IEEE 1149.1 16-state TMS machine plus instruction register (IR), bypass register and IDCODE register.
- Decodes the latched instruction into DR-select strobes and muxes TDO from IR, bypass, IDCODE or an external user data register (the boundary scan chain).
- Sits between the chip JTAG pins and the scan chains of the DFT wrapper around the ripple adder.
- Replaces gated clocks with clock enables.

Parameters:
- IR_WIDTH, 4, instruction register length (>=2).
- IDCODE_VAL, 32'h1000_0001, value captured by IDCODE DR; bit0 must be 1.
- OPC_EXTEST, 4'b0000, EXTEST opcode; selects user DR.
- OPC_SAMPLE, 4'b0001, SAMPLE/PRELOAD opcode; selects user DR.
- OPC_IDCODE, 4'b0010, IDCODE opcode; reset instruction.
- IR_CAPTURE, 4'b0101, pattern loaded in Capture_IR; two LSBs must be 2'b01.
- Opcode parameters are IR_WIDTH bits wide. All-ones is always BYPASS; any undefined opcode also selects bypass.

Ports:
- TCK, input, 1, test clock; the only clock.
- TRST_N, input, 1, asynchronous active-low reset.
- TMS, input, 1, mode select, sampled on posedge TCK.
- TDI, input, 1, serial data in, sampled on posedge TCK.
- TDO, output, 1, serial data out, registered on negedge TCK.
- TDO_EN, output, 1, TDO driver enable, registered on negedge TCK.
- UserTDO, input, 1, serial out of the external user DR.
- TapState, output, 4, current state; encoding in package.
- CaptureDR, output, 1, high in Capture_DR.
- ShiftDR, output, 1, high in Shift_DR.
- UpdateDR, output, 1, high in Update_DR.
- ShiftIR, output, 1, high in Shift_IR.
- Instr, output, IR_WIDTH, latched instruction.
- SelUser, output, 1, Instr is EXTEST or SAMPLE.
- SelExtest, output, 1, Instr is EXTEST; drives boundary mode.
- Reset, output, 1, high in Test_Logic_Reset or while TRST_N=0.

Behaviour:
- State machine:
  - Standard 1149.1 transitions. Encoding: TLR=0, RTI=1, SelDR=2, CapDR=3, ShDR=4, Ex1DR=5, PauDR=6, Ex2DR=7, UpdDR=8, SelIR=9, CapIR=10, ShIR=11, Ex1IR=12, PauIR=13, Ex2IR=14, UpdIR=15.
  - State register updates on posedge TCK.
  - Five consecutive TMS=1 edges reach TLR from any state.
- TRST_N=0 (asynchronous):
  - TapState=TLR, Instr=OPC_IDCODE, IR shift=0, bypass=0, IDCODE shift=0, TDO=0, TDO_EN=0.
  - Holds while low. The first posedge after release samples TMS.
- While in TLR: at each posedge Instr<=OPC_IDCODE (synchronous reset of the instruction).
- IR shift register, posedge TCK:
  - CapIR: load IR_CAPTURE.
  - ShIR: shift right; TDI enters the MSB; the LSB feeds TDO.
  - Other states: hold.
- Instruction latch: posedge TCK with TapState=UpdIR, Instr<=IR shift. Instr is therefore valid from the cycle after Update_IR. It never changes during Shift_IR.
- Bypass register (1 bit): CapDR with bypass selected loads 0; ShDR shifts in TDI.
- IDCODE register (32 bits): CapDR with IDCODE selected loads IDCODE_VAL; ShDR shifts right with TDI into bit31.
- User DR: only strobes (CaptureDR, ShiftDR, UpdateDR) are exported. The external chain clocks on TCK gated by these levels.
- Decode outputs (Sel*, CaptureDR, ShiftDR, UpdateDR, ShiftIR) are combinational from TapState and Instr.
- TDO, negedge TCK:
  - ShIR: TDO <= IR LSB.
  - ShDR: TDO <= LSB of the selected DR.
  - Otherwise TDO <= 0.
  - TDO_EN <= ShIR|ShDR.
  - Data therefore changes half a cycle after the shift edge.
- Unselected DRs hold their value.
- An IR or DR shift aborted by TRST_N loses the shifted data. Instr reverts to IDCODE.
- Pause states hold all registers. Ex2 to Shift resumes without re-capture.

Decomposition:
- Package jtag_pkg:
  - State encoding constants (TAP_TLR..TAP_UPDIR).
  - Default opcode constants.
  - IDCODE length (32).
- Sub-module jtag_tap_fsm: state register, next-state logic, state decode. Top-level jtag_tap_ctrl holds the IR, DRs, decode and TDO mux.

Test Plan:
- Reset: TRST_N pulse low mid-ShDR -> immediately TapState=0, Instr=4'b0010, TDO_EN=0. TMS=0 one edge -> TapState=1.
- TMS recovery: from PauIR, apply five TMS=1 edges -> TapState=0. Instr=OPC_IDCODE on the cycle after TLR is reached.
- IDCODE read: TLR -> RTI -> SelDR -> CapDR, then 32 ShDR edges with TDI=0 -> TDO bits LSB-first = 32'h1000_0001; the bit after that = 0.
- IR scan: shift 4'b1111 with TMS=1 on the last bit -> TDO shows 1,0,1,0 (IR_CAPTURE LSB-first). After UpdIR, Instr=4'b1111 and the bypass path is selected.
- Bypass: with Instr=1111, shift TDI=1,0,1,1 in ShDR -> TDO=0,1,0,1 (one-bit delay, captured 0 first).
- EXTEST: load 4'b0000 -> SelUser=1, SelExtest=1. In ShDR, TDO follows UserTDO each negedge. CaptureDR/UpdateDR pulse exactly one TCK in CapDR/UpdDR.

Source files
------------

// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - TAP state encoding, default opcodes and IDCODE length
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_TLR   = 4'd0,
        TAP_RTI   = 4'd1,
        TAP_SELDR = 4'd2,
        TAP_CAPDR = 4'd3,
        TAP_SHDR  = 4'd4,
        TAP_EX1DR = 4'd5,
        TAP_PAUDR = 4'd6,
        TAP_EX2DR = 4'd7,
        TAP_UPDDR = 4'd8,
        TAP_SELIR = 4'd9,
        TAP_CAPIR = 4'd10,
        TAP_SHIR  = 4'd11,
        TAP_EX1IR = 4'd12,
        TAP_PAUIR = 4'd13,
        TAP_EX2IR = 4'd14,
        TAP_UPDIR = 4'd15
    } tap_state_e;

    localparam int IDCODE_LEN = 32;

    localparam logic [3:0]            DEF_OPC_EXTEST = 4'b0000;
    localparam logic [3:0]            DEF_OPC_SAMPLE = 4'b0001;
    localparam logic [3:0]            DEF_OPC_IDCODE = 4'b0010;
    localparam logic [3:0]            DEF_IR_CAPTURE = 4'b0101;
    localparam logic [IDCODE_LEN-1:0] DEF_IDCODE     = 32'h1000_0001;

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// rtl/jtag_tap_ctrl_if.sv - JTAG pin and scan-strobe bundle between tester/wrapper and TAP
// Signals: TMS/TDI/UserTDO toward the TAP; TDO/TDO_EN, TapState, DR/IR strobes,
// Instr, SelUser/SelExtest and Reset back from the TAP.
// master: the tester / DFT wrapper side. slave: the TAP controller.
interface jtag_tap_ctrl_if import jtag_pkg::*; #(
    parameter int IR_WIDTH = 4
) ();
    logic                TMS;
    logic                TDI;
    logic                UserTDO;
    logic                TDO;
    logic                TDO_EN;
    tap_state_e          TapState;
    logic                CaptureDR;
    logic                ShiftDR;
    logic                UpdateDR;
    logic                ShiftIR;
    logic [IR_WIDTH-1:0] Instr;
    logic                SelUser;
    logic                SelExtest;
    logic                Reset;

    modport master (
        output TMS, TDI, UserTDO,
        input  TDO, TDO_EN, TapState, CaptureDR, ShiftDR, UpdateDR, ShiftIR,
        input  Instr, SelUser, SelExtest, Reset
    );

    modport slave (
        input  TMS, TDI, UserTDO,
        output TDO, TDO_EN, TapState, CaptureDR, ShiftDR, UpdateDR, ShiftIR,
        output Instr, SelUser, SelExtest, Reset
    );
endinterface

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 16-state TMS state machine with state decode
// Ports: tck/trst_n clock and async reset, tms mode select; state is the
// current TAP state, the remaining outputs are one-hot decodes of it.
module jtag_tap_fsm import jtag_pkg::*; (
    input  logic       tck,
    input  logic       trst_n,
    input  logic       tms,
    output tap_state_e state,
    output logic       in_tlr,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir
);

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state <= TAP_TLR;
        end else begin
            case (state)
                TAP_TLR:   state <= tms ? TAP_TLR   : TAP_RTI;
                TAP_RTI:   state <= tms ? TAP_SELDR : TAP_RTI;
                TAP_SELDR: state <= tms ? TAP_SELIR : TAP_CAPDR;
                TAP_CAPDR: state <= tms ? TAP_EX1DR : TAP_SHDR;
                TAP_SHDR:  state <= tms ? TAP_EX1DR : TAP_SHDR;
                TAP_EX1DR: state <= tms ? TAP_UPDDR : TAP_PAUDR;
                TAP_PAUDR: state <= tms ? TAP_EX2DR : TAP_PAUDR;
                TAP_EX2DR: state <= tms ? TAP_UPDDR : TAP_SHDR;
                TAP_UPDDR: state <= tms ? TAP_SELDR : TAP_RTI;
                TAP_SELIR: state <= tms ? TAP_TLR   : TAP_CAPIR;
                TAP_CAPIR: state <= tms ? TAP_EX1IR : TAP_SHIR;
                TAP_SHIR:  state <= tms ? TAP_EX1IR : TAP_SHIR;
                TAP_EX1IR: state <= tms ? TAP_UPDIR : TAP_PAUIR;
                TAP_PAUIR: state <= tms ? TAP_EX2IR : TAP_PAUIR;
                TAP_EX2IR: state <= tms ? TAP_UPDIR : TAP_SHIR;
                TAP_UPDIR: state <= tms ? TAP_SELDR : TAP_RTI;
                default:   state <= TAP_TLR;
            endcase
        end
    end

    assign in_tlr     = (state == TAP_TLR);
    assign capture_dr = (state == TAP_CAPDR);
    assign shift_dr   = (state == TAP_SHDR);
    assign update_dr  = (state == TAP_UPDDR);
    assign capture_ir = (state == TAP_CAPIR);
    assign shift_ir   = (state == TAP_SHIR);
    assign update_ir  = (state == TAP_UPDIR);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - JTAG TAP controller: IR, bypass and IDCODE DRs, decode, TDO mux
// Ports: TCK test clock, TRST_N async active-low reset, jtag (slave) carrying
// TMS/TDI/UserTDO in and TDO/TDO_EN, TapState, scan strobes, Instr and selects out.
module jtag_tap_ctrl import jtag_pkg::*; #(
    parameter int                     IR_WIDTH   = 4,
    parameter logic [IDCODE_LEN-1:0]  IDCODE_VAL = DEF_IDCODE,
    parameter logic [IR_WIDTH-1:0]    OPC_EXTEST = IR_WIDTH'(DEF_OPC_EXTEST),
    parameter logic [IR_WIDTH-1:0]    OPC_SAMPLE = IR_WIDTH'(DEF_OPC_SAMPLE),
    parameter logic [IR_WIDTH-1:0]    OPC_IDCODE = IR_WIDTH'(DEF_OPC_IDCODE),
    parameter logic [IR_WIDTH-1:0]    IR_CAPTURE = IR_WIDTH'(DEF_IR_CAPTURE)
) (
    input  logic                  TCK,
    input  logic                  TRST_N,
    jtag_tap_ctrl_if.slave        jtag
);

    tap_state_e tap_state;
    logic       in_tlr;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic       capture_ir;
    logic       shift_ir;
    logic       update_ir;

    logic [IR_WIDTH-1:0]   ir_shift;
    logic [IR_WIDTH-1:0]   instr;
    logic                  bypass_reg;
    logic [IDCODE_LEN-1:0] idcode_shift;
    logic                  tdo_q;
    logic                  tdo_en_q;

    logic all_ones;
    logic sel_extest;
    logic sel_sample;
    logic sel_user;
    logic sel_idcode;
    logic sel_bypass;
    logic dr_lsb;

    jtag_tap_fsm u_fsm (
        .tck        (TCK),
        .trst_n     (TRST_N),
        .tms        (jtag.TMS),
        .state      (tap_state),
        .in_tlr     (in_tlr),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir)
    );

    // All-ones is BYPASS even if a parameterised opcode happens to collide
    // with it; anything not recognised also falls through to bypass.
    assign all_ones   = &instr;
    assign sel_extest = (instr == OPC_EXTEST) && !all_ones;
    assign sel_sample = (instr == OPC_SAMPLE) && !all_ones;
    assign sel_user   = sel_extest || sel_sample;
    assign sel_idcode = (instr == OPC_IDCODE) && !all_ones && !sel_user;
    assign sel_bypass = !sel_user && !sel_idcode;

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_shift <= '0;
            instr    <= OPC_IDCODE;
        end else begin
            if (capture_ir) begin
                ir_shift <= IR_CAPTURE;
            end else if (shift_ir) begin
                ir_shift <= {jtag.TDI, ir_shift[IR_WIDTH-1:1]};
            end

            // Instr only moves on leaving Update_IR, so it is stable while
            // a new instruction is being shifted in.
            if (in_tlr) begin
                instr <= OPC_IDCODE;
            end else if (update_ir) begin
                instr <= ir_shift;
            end
        end
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            bypass_reg   <= 1'b0;
            idcode_shift <= '0;
        end else begin
            if (sel_bypass) begin
                if (capture_dr) begin
                    bypass_reg <= 1'b0;
                end else if (shift_dr) begin
                    bypass_reg <= jtag.TDI;
                end
            end

            if (sel_idcode) begin
                if (capture_dr) begin
                    idcode_shift <= IDCODE_VAL;
                end else if (shift_dr) begin
                    idcode_shift <= {jtag.TDI, idcode_shift[IDCODE_LEN-1:1]};
                end
            end
        end
    end

    always_comb begin
        dr_lsb = bypass_reg;
        if (sel_user) begin
            dr_lsb = jtag.UserTDO;
        end else if (sel_idcode) begin
            dr_lsb = idcode_shift[0];
        end
    end

    // TDO is launched on the falling edge so the receiver sees stable data
    // across the next rising edge.
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_en_q <= shift_ir || shift_dr;
            if (shift_ir) begin
                tdo_q <= ir_shift[0];
            end else if (shift_dr) begin
                tdo_q <= dr_lsb;
            end else begin
                tdo_q <= 1'b0;
            end
        end
    end

    assign jtag.TDO       = tdo_q;
    assign jtag.TDO_EN    = tdo_en_q;
    assign jtag.TapState  = tap_state;
    assign jtag.CaptureDR = capture_dr;
    assign jtag.ShiftDR   = shift_dr;
    assign jtag.UpdateDR  = update_dr;
    assign jtag.ShiftIR   = shift_ir;
    assign jtag.Instr     = instr;
    assign jtag.SelUser   = sel_user;
    assign jtag.SelExtest = sel_extest;
    assign jtag.Reset     = in_tlr;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb/tb_jtag_tap_ctrl.sv - self-checking bench for jtag_tap_ctrl against a behavioural TAP model
module tb_jtag_tap_ctrl;

    logic tck;
    logic trst_n;

    jtag_tap_ctrl_if #(.IR_WIDTH(4)) jif ();

    jtag_tap_ctrl dut (
        .TCK    (tck),
        .TRST_N (trst_n),
        .jtag   (jif)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    int n_cmp = 0;
    int n_err = 0;

    // Standard 1149.1 successor table indexed by state number, one per TMS value.
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int          m_state;
    logic [3:0]  m_ir;
    logic [3:0]  m_instr;
    logic        m_byp;
    logic [31:0] m_id;
    logic        m_tdo;
    logic        m_tdo_en;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // 0 = user chain, 1 = IDCODE, 2 = bypass
    function automatic int m_sel(input logic [3:0] ins);
        if (ins == 4'hF)                 return 2;
        if (ins == 4'h0 || ins == 4'h1)  return 0;
        if (ins == 4'h2)                 return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_ir     = 4'h0;
        m_instr  = 4'h2;
        m_byp    = 1'b0;
        m_id     = 32'h0;
        m_tdo    = 1'b0;
        m_tdo_en = 1'b0;
    endtask

    task automatic compare_all();
        chk("state",     32'(jif.TapState),  32'(m_state));
        chk("instr",     32'(jif.Instr),     32'(m_instr));
        chk("tdo",       32'(jif.TDO),       32'(m_tdo));
        chk("tdo_en",    32'(jif.TDO_EN),    32'(m_tdo_en));
        chk("capdr",     32'(jif.CaptureDR), 32'(m_state == 3));
        chk("shdr",      32'(jif.ShiftDR),   32'(m_state == 4));
        chk("upddr",     32'(jif.UpdateDR),  32'(m_state == 8));
        chk("shir",      32'(jif.ShiftIR),   32'(m_state == 11));
        chk("seluser",   32'(jif.SelUser),   32'(m_sel(m_instr) == 0));
        chk("selextest", 32'(jif.SelExtest), 32'(m_instr == 4'h0));
        chk("reset",     32'(jif.Reset),     32'(m_state == 0));
    endtask

    // One full TCK period: drive inputs, advance the model by one rising edge,
    // then compare after the falling edge has launched TDO.
    task automatic tick(input bit tms, input bit tdi, input bit utdo);
        int sel;
        jif.TMS     = tms;
        jif.TDI     = tdi;
        jif.UserTDO = utdo;
        sel = m_sel(m_instr);
        if (m_state == 10) m_ir = 4'h5;
        else if (m_state == 11) m_ir = {tdi, m_ir[3:1]};
        if (m_state == 3) begin
            if (sel == 2) m_byp = 1'b0;
            if (sel == 1) m_id  = 32'h1000_0001;
        end else if (m_state == 4) begin
            if (sel == 2) m_byp = tdi;
            if (sel == 1) m_id  = {tdi, m_id[31:1]};
        end
        if (m_state == 0) m_instr = 4'h2;
        else if (m_state == 15) m_instr = m_ir;
        m_state = tms ? nxt1[m_state] : nxt0[m_state];
        sel = m_sel(m_instr);
        m_tdo_en = (m_state == 11) || (m_state == 4);
        if (m_state == 11)     m_tdo = m_ir[0];
        else if (m_state == 4) m_tdo = (sel == 0) ? utdo : (sel == 1) ? m_id[0] : m_byp;
        else                   m_tdo = 1'b0;
        @(posedge tck);
        @(negedge tck);
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse placed between a falling and the next rising edge.
    task automatic pulse_reset();
        #1 trst_n = 1'b0;
        #1;
        chk("rst_state",  32'(jif.TapState), 32'd0);
        chk("rst_instr",  32'(jif.Instr),    32'h2);
        chk("rst_tdo_en", 32'(jif.TDO_EN),   32'd0);
        chk("rst_tdo",    32'(jif.TDO),      32'd0);
        chk("rst_reset",  32'(jif.Reset),    32'd1);
        model_reset();
        #1 trst_n = 1'b1;
    endtask

    task automatic load_ir(input logic [3:0] code);
        tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
        for (int i = 0; i < 4; i++) tick(i == 3, code[i], 0);
        tick(1, 0, 0); tick(0, 0, 0);
    endtask

    logic [31:0] word;
    logic [3:0]  nib;
    bit          u;

    initial begin
        trst_n      = 1'b0;
        jif.TMS     = 1'b0;
        jif.TDI     = 1'b0;
        jif.UserTDO = 1'b0;
        model_reset();
        #12;
        chk("por_state",  32'(jif.TapState), 32'd0);
        chk("por_instr",  32'(jif.Instr),    32'h2);
        chk("por_tdo_en", 32'(jif.TDO_EN),   32'd0);
        trst_n = 1'b1;
        @(negedge tck); #1;

        // Reset asserted in the middle of a DR shift
        tick(0, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 1, 0); tick(0, 1, 0);
        chk("shdr_tdo_en", 32'(jif.TDO_EN), 32'd1);
        pulse_reset();
        tick(0, 0, 0);
        chk("post_rst_rti", 32'(jif.TapState), 32'd1);

        // TMS recovery from Pause_IR
        tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 1, 0); tick(1, 1, 0); tick(0, 0, 0);
        chk("at_pauir", 32'(jif.TapState), 32'd13);
        for (int i = 0; i < 5; i++) tick(1, 0, 0);
        chk("recover_tlr", 32'(jif.TapState), 32'd0);
        tick(1, 0, 0);
        chk("recover_instr", 32'(jif.Instr), 32'h2);

        // IDCODE read-out, LSB first
        pulse_reset();
        tick(0, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
        word = 32'h0;
        for (int i = 0; i < 32; i++) begin
            tick(0, 0, 0);
            word[i] = jif.TDO;
        end
        chk("idcode_word", word, 32'h1000_0001);
        tick(0, 0, 0);
        chk("idcode_after", 32'(jif.TDO), 32'd0);
        tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0);

        // IR scan of 1111: capture pattern appears on TDO
        tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
        tick(0, 0, 0); nib[0] = jif.TDO;
        for (int i = 1; i < 4; i++) begin
            tick(0, 1, 0);
            nib[i] = jif.TDO;
        end
        tick(1, 1, 0);
        chk("ir_capture", 32'(nib), 32'h5);
        tick(1, 0, 0); tick(0, 0, 0);
        chk("ir_bypass_instr", 32'(jif.Instr),   32'hF);
        chk("ir_bypass_user",  32'(jif.SelUser), 32'd0);

        // Bypass: one-bit delay with captured 0 first
        tick(1, 0, 0); tick(0, 0, 0);
        tick(0, 0, 0); nib[0] = jif.TDO;
        tick(0, 1, 0); nib[1] = jif.TDO;
        tick(0, 0, 0); nib[2] = jif.TDO;
        tick(0, 1, 0); nib[3] = jif.TDO;
        tick(1, 1, 0);
        chk("bypass_seq", 32'(nib), 32'hA);
        tick(1, 0, 0); tick(0, 0, 0);

        // EXTEST: user chain strobes and TDO pass-through
        load_ir(4'h0);
        chk("ext_seluser",   32'(jif.SelUser),   32'd1);
        chk("ext_selextest", 32'(jif.SelExtest), 32'd1);
        tick(1, 0, 0); tick(0, 0, 0);
        chk("ext_capdr", 32'(jif.CaptureDR), 32'd1);
        for (int i = 0; i < 8; i++) begin
            u = 1'($urandom_range(0, 1));
            tick(0, 0, u);
            chk("ext_tdo", 32'(jif.TDO), 32'(u));
        end
        chk("ext_capdr_low", 32'(jif.CaptureDR), 32'd0);
        tick(1, 0, 0); tick(1, 0, 0);
        chk("ext_upddr", 32'(jif.UpdateDR), 32'd1);
        tick(0, 0, 0);
        chk("ext_upddr_low", 32'(jif.UpdateDR), 32'd0);

        // Randomised walk through the state graph with occasional async resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 249) == 0) pulse_reset();
            if ($urandom_range(0, 99) < 3) load_ir(4'($urandom_range(0, 15)));
            tick(1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
